// File: rtl/sram_loader.sv
// sram_loader: packs an incoming byte stream into 16-bit words and writes
// them to an asynchronous SRAM with a SETUP / WRITE / HOLD strobe sequence.
// Optional read-back verify is compiled in with `define SRAM_LOADER_VERIFY_EN.
// Without that macro the VRD/VCMP states do not exist, ERR is tied to 0
// and SRAM_OE is tied to 1.
// All strobes and status outputs come straight from registers. The
// asynchronous reset therefore releases WE/DOE immediately.

module sram_loader #(
    parameter int WE_CYCLES = 2,
    parameter int MAX_WORDS = 262144
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    input  logic        IN_LAST,
    output logic        IN_READY,
    output logic [17:0] SRAM_A,
    output logic [15:0] SRAM_DOUT,
    output logic        SRAM_DOE,
    input  logic [15:0] SRAM_D,
    output logic        SRAM_WE,
    output logic        SRAM_CE,
    output logic        SRAM_OE,
    output logic        SRAM_LB,
    output logic        SRAM_UB,
    output logic [17:0] WORD_COUNT,
    output logic        BUSY,
    output logic        DONE,
    output logic        FULL,
    output logic        ERR
);

    typedef enum logic [2:0] {
        ST_LO    = 3'd0,
        ST_HI    = 3'd1,
        ST_SETUP = 3'd2,
        ST_WRITE = 3'd3,
        ST_HOLD  = 3'd4,
`ifdef SRAM_LOADER_VERIFY_EN
        ST_VRD   = 3'd5,
        ST_VCMP  = 3'd6,
`endif
        ST_FIN   = 3'd7
    } state_t;

    localparam logic [3:0]  WE_LAST = 4'(WE_CYCLES - 1);
    localparam logic [18:0] MAX_W   = 19'(MAX_WORDS);

    // Counters stop at all-ones so neither the address nor the count can wrap
    function automatic logic [17:0] sat_inc18(input logic [17:0] v);
        if (v == 18'h3FFFF) begin
            sat_inc18 = v;
        end else begin
            sat_inc18 = v + 18'd1;
        end
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] word_r;
    logic [15:0] word_nxt_s;
    logic        last_r;
    logic        last_nxt_s;
    logic [17:0] addr_r;
    logic [17:0] word_count_r;
    logic [3:0]  we_cnt_r;
    logic        done_r;
    logic        full_r;

    logic        in_ready_r;
    logic        busy_r;
    logic [17:0] sram_a_r;
    logic [15:0] sram_dout_r;
    logic        sram_doe_r;
    logic        sram_we_r;
    logic        sram_ce_r;

    logic        accept_s;
    logic        hit_s;
    logic        commit_end_s;
    logic        full_set_s;
    logic        done_nxt_s;
    logic        full_nxt_s;
    logic        ready_nxt_s;
    logic        active_nxt_s;
    logic        write_nxt_s;
    logic        drive_nxt_s;
    logic        enter_setup_s;

`ifdef SRAM_LOADER_VERIFY_EN
    logic        full_pend_r;
    logic        err_r;
    logic        sram_oe_r;
    logic        read_nxt_s;
`else
    logic        unused_sram_d_s;
    assign unused_sram_d_s = ^SRAM_D;
`endif

    assign accept_s = IN_VALID & in_ready_r;

    // Next-state and word assembly: byte latching and the strobe sequence
    always_comb begin
        state_nxt_s = state_r;
        word_nxt_s  = word_r;
        last_nxt_s  = last_r;
        case (state_r)
            ST_LO: begin
                if (accept_s) begin
                    word_nxt_s[7:0] = IN_DATA;
                    last_nxt_s      = IN_LAST;
                    if (IN_LAST) begin
                        word_nxt_s[15:8] = 8'h00;
                        state_nxt_s      = ST_SETUP;
                    end else begin
                        state_nxt_s = ST_HI;
                    end
                end else begin
                    state_nxt_s = ST_LO;
                end
            end
            ST_HI: begin
                if (accept_s) begin
                    word_nxt_s[15:8] = IN_DATA;
                    last_nxt_s       = IN_LAST;
                    state_nxt_s      = ST_SETUP;
                end else begin
                    state_nxt_s = ST_HI;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (we_cnt_r == WE_LAST) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_HOLD: begin
`ifdef SRAM_LOADER_VERIFY_EN
                state_nxt_s = ST_VRD;
`else
                if (last_r) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_LO;
                end
`endif
            end
`ifdef SRAM_LOADER_VERIFY_EN
            ST_VRD: begin
                state_nxt_s = ST_VCMP;
            end
            ST_VCMP: begin
                if (last_r) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_LO;
                end
            end
`endif
            ST_FIN: begin
                state_nxt_s = ST_FIN;
            end
            default: begin
                state_nxt_s = ST_LO;
            end
        endcase
    end

    // Status flags and strobe decode for the state being entered
    always_comb begin
        hit_s = (({1'b0, word_count_r} + 19'd1) == MAX_W);
`ifdef SRAM_LOADER_VERIFY_EN
        commit_end_s = (state_r == ST_VCMP);
        full_set_s   = commit_end_s & full_pend_r;
        read_nxt_s   = (state_nxt_s == ST_VRD) | (state_nxt_s == ST_VCMP);
`else
        commit_end_s = (state_r == ST_HOLD);
        full_set_s   = commit_end_s & hit_s;
`endif
        done_nxt_s    = done_r | (commit_end_s & last_r);
        full_nxt_s    = full_r | full_set_s;
        ready_nxt_s   = ((state_nxt_s == ST_LO) | (state_nxt_s == ST_HI))
                        & ~full_nxt_s & ~done_nxt_s;
        write_nxt_s   = (state_nxt_s == ST_WRITE);
        drive_nxt_s   = (state_nxt_s == ST_SETUP) | (state_nxt_s == ST_WRITE)
                        | (state_nxt_s == ST_HOLD);
        active_nxt_s  = drive_nxt_s
`ifdef SRAM_LOADER_VERIFY_EN
                        | read_nxt_s
`endif
                        ;
        enter_setup_s = (state_nxt_s == ST_SETUP) & (state_r != ST_SETUP);
    end

    // State, word, address and sticky status registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_LO;
            word_r       <= 16'h0000;
            last_r       <= 1'b0;
            addr_r       <= 18'd0;
            word_count_r <= 18'd0;
            we_cnt_r     <= 4'd0;
            done_r       <= 1'b0;
            full_r       <= 1'b0;
`ifdef SRAM_LOADER_VERIFY_EN
            full_pend_r  <= 1'b0;
            err_r        <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            word_r   <= word_nxt_s;
            last_r   <= last_nxt_s;
            done_r   <= done_nxt_s;
            full_r   <= full_nxt_s;
            if (state_r == ST_WRITE) begin
                we_cnt_r <= we_cnt_r + 4'd1;
            end else begin
                we_cnt_r <= 4'd0;
            end
            if (state_r == ST_HOLD) begin
                addr_r       <= sat_inc18(addr_r);
                word_count_r <= sat_inc18(word_count_r);
            end else begin
                addr_r       <= addr_r;
                word_count_r <= word_count_r;
            end
`ifdef SRAM_LOADER_VERIFY_EN
            if (state_r == ST_HOLD) begin
                full_pend_r <= hit_s;
            end else begin
                full_pend_r <= full_pend_r;
            end
            if ((state_r == ST_VCMP) && (SRAM_D != word_r)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
`endif
        end
    end

    // Registered SRAM strobes and handshake; address/data latch on entry to SETUP
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            sram_a_r    <= 18'd0;
            sram_dout_r <= 16'h0000;
            sram_doe_r  <= 1'b0;
            sram_we_r   <= 1'b1;
            sram_ce_r   <= 1'b1;
`ifdef SRAM_LOADER_VERIFY_EN
            sram_oe_r   <= 1'b1;
`endif
        end else begin
            in_ready_r <= ready_nxt_s;
            busy_r     <= active_nxt_s;
            sram_doe_r <= drive_nxt_s;
            sram_we_r  <= ~write_nxt_s;
            sram_ce_r  <= ~active_nxt_s;
`ifdef SRAM_LOADER_VERIFY_EN
            sram_oe_r  <= ~read_nxt_s;
`endif
            if (enter_setup_s) begin
                sram_a_r    <= addr_r;
                sram_dout_r <= word_nxt_s;
            end else begin
                sram_a_r    <= sram_a_r;
                sram_dout_r <= sram_dout_r;
            end
        end
    end

    assign IN_READY   = in_ready_r;
    assign BUSY       = busy_r;
    assign SRAM_A     = sram_a_r;
    assign SRAM_DOUT  = sram_dout_r;
    assign SRAM_DOE   = sram_doe_r;
    assign SRAM_WE    = sram_we_r;
    assign SRAM_CE    = sram_ce_r;
    assign SRAM_LB    = 1'b0;
    assign SRAM_UB    = 1'b0;
    assign WORD_COUNT = word_count_r;
    assign DONE       = done_r;
    assign FULL       = full_r;
`ifdef SRAM_LOADER_VERIFY_EN
    assign SRAM_OE    = sram_oe_r;
    assign ERR        = err_r;
`else
    assign SRAM_OE    = 1'b1;
    assign ERR        = 1'b0;
`endif

endmodule
